intersection_controller: RTL and testbench

Two-way intersection sequencer that drives the per-direction `traffic_light` instances. It produces the shared 7-bit countdown `master_timer` and one enable per approach (north-south, east-west). The timer and enables step on a one-second tick. Requests from vehicle sensors and a pedestrian push-button are latched, and they steer phase selection and green extension.

---
 rtl/intersection_controller.sv | 173 +++++++++++++++++
 tb/tb_intersection_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_controller.sv
// ---------------------------------------------------------------------------
// intersection_controller
//
// Two-way intersection sequencer. Cycles NS_GO -> NS_CLEAR -> EW_GO ->
// EW_CLEAR on the one-second tick. It produces a shared countdown for the
// per-direction traffic_light instances and one enable per approach.
// Vehicle and pedestrian requests are latched. They steer which GO phase
// follows a clearance. A pending pedestrian request extends the next
// north-south green.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   sec_tick     in   one-cycle pulse, once per second
//   ns_request   in   north-south vehicle sensor (level or pulse)
//   ew_request   in   east-west vehicle sensor (level or pulse)
//   ped_request  in   pedestrian push-button pulse (crosses with NS traffic)
//   master_timer out  7-bit countdown shared by both traffic_light instances
//   ns_enable    out  north-south traffic_light enable
//   ew_enable    out  east-west traffic_light enable
//   walk         out  pedestrian walk indication
//   phase        out  current state: 0 NS_GO, 1 NS_CLEAR, 2 EW_GO, 3 EW_CLEAR
// ---------------------------------------------------------------------------
module intersection_controller #(
    parameter int GREEN_TIME = 30,
    parameter int CLEAR_TIME = 2,
    parameter int PED_EXTRA  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       ns_request,
    input  logic       ew_request,
    input  logic       ped_request,
    output logic [6:0] master_timer,
    output logic       ns_enable,
    output logic       ew_enable,
    output logic       walk,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        NS_GO    = 2'd0,
        NS_CLEAR = 2'd1,
        EW_GO    = 2'd2,
        EW_CLEAR = 2'd3
    } state_t;

    localparam logic [6:0] GREEN_LOAD = 7'(GREEN_TIME);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_TIME - 1);
    // The extended load is formed in 8 bits and saturated to the 7-bit timer.
    localparam logic [7:0] PED_SUM    = 8'(GREEN_TIME) + 8'(PED_EXTRA);
    localparam logic [6:0] PED_LOAD   = (PED_SUM > 8'd127) ? 7'd127 : PED_SUM[6:0];

    state_t     state, state_next;
    logic [6:0] timer_next;
    logic [3:0] clr_cnt, clr_next;
    logic       ns_req_l, ns_req_next;
    logic       ew_req_l, ew_req_next;
    logic       ped_l, ped_next;
    logic       walk_next;
    logic       ns_en_next, ew_en_next;
    logic       ns_demand, ew_demand;
    logic       enter_ns, enter_ew;

    assign phase = state;

    // State, timer, latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EW_CLEAR;
            master_timer <= 7'd0;
            clr_cnt      <= CLEAR_LOAD;
            ns_req_l     <= 1'b0;
            ew_req_l     <= 1'b0;
            ped_l        <= 1'b0;
            walk         <= 1'b0;
            ns_enable    <= 1'b0;
            ew_enable    <= 1'b0;
        end else begin
            state        <= state_next;
            master_timer <= timer_next;
            clr_cnt      <= clr_next;
            ns_req_l     <= ns_req_next;
            ew_req_l     <= ew_req_next;
            ped_l        <= ped_next;
            walk         <= walk_next;
            ns_enable    <= ns_en_next;
            ew_enable    <= ew_en_next;
        end
    end

    // Next-state, timer and latch logic. The latches update every cycle.
    // The state and the counters only move on sec_tick.
    always_comb begin
        state_next  = state;
        timer_next  = master_timer;
        clr_next    = clr_cnt;
        ns_req_next = ns_req_l;
        ew_req_next = ew_req_l;
        ped_next    = ped_l;
        walk_next   = walk;
        enter_ns    = 1'b0;
        enter_ew    = 1'b0;

        ns_demand = ns_req_l | ped_l;
        ew_demand = ew_req_l;

        // A request for a direction that already has green is ignored.
        // The button is likewise ignored while its walk is being shown.
        if (ns_request && state != NS_GO) ns_req_next = 1'b1;
        if (ew_request && state != EW_GO) ew_req_next = 1'b1;
        if (ped_request && !(state == NS_GO && walk)) ped_next = 1'b1;

        if (sec_tick) begin
            case (state)
                NS_GO, EW_GO: begin
                    if (master_timer != 7'd0) begin
                        timer_next = master_timer - 7'd1;
                        if (master_timer == 7'd4) walk_next = 1'b0;
                    end else begin
                        state_next = (state == NS_GO) ? NS_CLEAR : EW_CLEAR;
                        clr_next   = CLEAR_LOAD;
                        walk_next  = 1'b0;
                    end
                end
                NS_CLEAR: begin
                    if (clr_cnt != 4'd0) begin
                        clr_next = clr_cnt - 4'd1;
                    end else if (ns_demand && !ew_demand) begin
                        enter_ns = 1'b1;
                    end else begin
                        enter_ew = 1'b1;
                    end
                end
                default: begin
                    if (clr_cnt != 4'd0) begin
                        clr_next = clr_cnt - 4'd1;
                    end else if (ew_demand && !ns_demand) begin
                        enter_ew = 1'b1;
                    end else begin
                        enter_ns = 1'b1;
                    end
                end
            endcase
        end

        // GO entry overrides the latch update above. A request asserted on the
        // entry cycle counts as served.
        if (enter_ns) begin
            state_next  = NS_GO;
            ns_req_next = 1'b0;
            if (ped_l) begin
                timer_next = PED_LOAD;
                ped_next   = 1'b0;
                walk_next  = 1'b1;
            end else begin
                timer_next = GREEN_LOAD;
                walk_next  = 1'b0;
            end
        end
        if (enter_ew) begin
            state_next  = EW_GO;
            ew_req_next = 1'b0;
            timer_next  = GREEN_LOAD;
            walk_next   = 1'b0;
        end

        ns_en_next = (state_next == NS_GO);
        ew_en_next = (state_next == EW_GO);
    end

endmodule

// File: tb/tb_intersection_controller.sv
// ---------------------------------------------------------------------------
// tb_intersection_controller
//
// Directed testbench for intersection_controller. Instance dut_a runs the
// full phase sequence with GREEN_TIME=10. Instance dut_b has
// GREEN_TIME=120 and its own reset, tick and button. It is used for the
// saturated pedestrian load.
// ---------------------------------------------------------------------------
module tb_intersection_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       ns_request = 1'b0;
    logic       ew_request = 1'b0;
    logic       ped_request = 1'b0;
    logic [6:0] a_timer;
    logic       a_ns_en, a_ew_en, a_walk;
    logic [1:0] a_phase;

    logic       b_rst_n = 1'b0;
    logic       b_tick = 1'b0;
    logic       b_ped = 1'b0;
    logic       b_idle = 1'b0;
    logic [6:0] b_timer;
    logic       b_ns_en, b_ew_en, b_walk;
    logic [1:0] b_phase;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    intersection_controller #(.GREEN_TIME(10), .CLEAR_TIME(2), .PED_EXTRA(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
        .ns_request(ns_request), .ew_request(ew_request), .ped_request(ped_request),
        .master_timer(a_timer), .ns_enable(a_ns_en), .ew_enable(a_ew_en),
        .walk(a_walk), .phase(a_phase)
    );

    intersection_controller #(.GREEN_TIME(120), .CLEAR_TIME(2), .PED_EXTRA(10)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .sec_tick(b_tick),
        .ns_request(b_idle), .ew_request(b_idle), .ped_request(b_ped),
        .master_timer(b_timer), .ns_enable(b_ns_en), .ew_enable(b_ew_en),
        .walk(b_walk), .phase(b_phase)
    );

    // Ticks on dut_a. Each tick is high for one cycle. The task returns on
    // the falling edge after the edge that consumed the tick.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sec_tick = 1'b1;
            @(negedge clk);
            sec_tick = 1'b0;
        end
    endtask

    task automatic b_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_tick = 1'b1;
            @(negedge clk);
            b_tick = 1'b0;
        end
    endtask

    // One-cycle pulse on a dut_a request input, with no tick:
    // 0 ns_request, 1 ew_request, 2 ped_request.
    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: ns_request = 1'b1;
            1: ew_request = 1'b1;
            default: ped_request = 1'b1;
        endcase
        @(negedge clk);
        ns_request = 1'b0;
        ew_request = 1'b0;
        ped_request = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_timer !== 7'd0) $display("[TB] FAIL reset_timer: got %0d expected 0", a_timer); else passed++;
        checks++; if (a_ns_en !== 1'b0) $display("[TB] FAIL reset_ns_en: got %b expected 0", a_ns_en); else passed++;
        checks++; if (a_ew_en !== 1'b0) $display("[TB] FAIL reset_ew_en: got %b expected 0", a_ew_en); else passed++;
        checks++; if (a_walk !== 1'b0) $display("[TB] FAIL reset_walk: got %b expected 0", a_walk); else passed++;
        checks++; if (a_phase !== 2'd3) $display("[TB] FAIL reset_phase: got %0d expected 3", a_phase); else passed++;
        rst_n = 1'b1;
        ticks(1);
        checks++; if (a_phase !== 2'd3) $display("[TB] FAIL first_clear_hold: got %0d expected 3", a_phase); else passed++;
        ticks(1);
        checks++; if (a_phase !== 2'd0) $display("[TB] FAIL first_ns_phase: got %0d expected 0", a_phase); else passed++;
        checks++; if (a_ns_en !== 1'b1) $display("[TB] FAIL first_ns_en: got %b expected 1", a_ns_en); else passed++;
        checks++; if (a_timer !== 7'd10) $display("[TB] FAIL first_ns_timer: got %0d expected 10", a_timer); else passed++;
        checks++; if (a_walk !== 1'b0) $display("[TB] FAIL first_ns_walk: got %b expected 0", a_walk); else passed++;
    endtask

    task automatic test_no_requests;
        ticks(10);
        checks++; if (a_timer !== 7'd0) $display("[TB] FAIL ns_red_timer: got %0d expected 0", a_timer); else passed++;
        checks++; if (a_ns_en !== 1'b1) $display("[TB] FAIL ns_red_en: got %b expected 1", a_ns_en); else passed++;
        ticks(1);
        checks++; if (a_ns_en !== 1'b0) $display("[TB] FAIL ns_clear_en: got %b expected 0", a_ns_en); else passed++;
        checks++; if (a_phase !== 2'd1) $display("[TB] FAIL ns_clear_phase: got %0d expected 1", a_phase); else passed++;
        ticks(1);
        checks++; if (a_phase !== 2'd1) $display("[TB] FAIL ns_clear_hold: got %0d expected 1", a_phase); else passed++;
        ticks(1);
        checks++; if (a_phase !== 2'd2) $display("[TB] FAIL ew_go_phase: got %0d expected 2", a_phase); else passed++;
        checks++; if (a_ew_en !== 1'b1) $display("[TB] FAIL ew_go_en: got %b expected 1", a_ew_en); else passed++;
        checks++; if (a_ns_en !== 1'b0) $display("[TB] FAIL ew_go_ns_en: got %b expected 0", a_ns_en); else passed++;
        checks++; if (a_timer !== 7'd10) $display("[TB] FAIL ew_go_timer: got %0d expected 10", a_timer); else passed++;
    endtask

    task automatic test_ped_extend;
        pulse(2);
        ticks(10);
        checks++; if (a_ew_en !== 1'b1) $display("[TB] FAIL ew_red_en: got %b expected 1", a_ew_en); else passed++;
        ticks(1);
        checks++; if (a_phase !== 2'd3) $display("[TB] FAIL ew_clear_phase: got %0d expected 3", a_phase); else passed++;
        checks++; if (a_ew_en !== 1'b0) $display("[TB] FAIL ew_clear_en: got %b expected 0", a_ew_en); else passed++;
        ticks(2);
        checks++; if (a_phase !== 2'd0) $display("[TB] FAIL ped_ns_phase: got %0d expected 0", a_phase); else passed++;
        checks++; if (a_timer !== 7'd20) $display("[TB] FAIL ped_ns_timer: got %0d expected 20", a_timer); else passed++;
        checks++; if (a_walk !== 1'b1) $display("[TB] FAIL ped_walk_on: got %b expected 1", a_walk); else passed++;
        // Button press while walk is shown must not be latched.
        pulse(2);
        ticks(16);
        checks++; if (a_timer !== 7'd4) $display("[TB] FAIL ped_timer4: got %0d expected 4", a_timer); else passed++;
        checks++; if (a_walk !== 1'b1) $display("[TB] FAIL ped_walk_at4: got %b expected 1", a_walk); else passed++;
        ticks(1);
        checks++; if (a_timer !== 7'd3) $display("[TB] FAIL ped_timer3: got %0d expected 3", a_timer); else passed++;
        checks++; if (a_walk !== 1'b0) $display("[TB] FAIL ped_walk_off: got %b expected 0", a_walk); else passed++;
    endtask

    task automatic test_saturation;
        b_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        b_ped = 1'b1;
        @(negedge clk);
        b_ped = 1'b0;
        b_ticks(1);
        checks++; if (b_phase !== 2'd3) $display("[TB] FAIL sat_clear_hold: got %0d expected 3", b_phase); else passed++;
        b_ticks(1);
        checks++; if (b_phase !== 2'd0) $display("[TB] FAIL sat_phase: got %0d expected 0", b_phase); else passed++;
        checks++; if (b_timer !== 7'd127) $display("[TB] FAIL sat_timer: got %0d expected 127", b_timer); else passed++;
        checks++; if (b_walk !== 1'b1) $display("[TB] FAIL sat_walk: got %b expected 1", b_walk); else passed++;
        checks++; if (b_ns_en !== 1'b1) $display("[TB] FAIL sat_ns_en: got %b expected 1", b_ns_en); else passed++;
    endtask

    task automatic test_ns_return;
        ticks(3);
        checks++; if (a_timer !== 7'd0) $display("[TB] FAIL ret_ns_red: got %0d expected 0", a_timer); else passed++;
        ticks(1);
        checks++; if (a_phase !== 2'd1) $display("[TB] FAIL ret_ns_clear: got %0d expected 1", a_phase); else passed++;
        pulse(0);
        ticks(2);
        checks++; if (a_phase !== 2'd0) $display("[TB] FAIL ret_ns_phase: got %0d expected 0", a_phase); else passed++;
        checks++; if (a_timer !== 7'd10) $display("[TB] FAIL ret_ns_timer: got %0d expected 10", a_timer); else passed++;
        checks++; if (a_walk !== 1'b0) $display("[TB] FAIL ret_ns_walk: got %b expected 0", a_walk); else passed++;
        checks++; if (a_ew_en !== 1'b0) $display("[TB] FAIL ret_ns_ew_en: got %b expected 0", a_ew_en); else passed++;
        // NS request during NS green is ignored and the entry cleared the latch,
        // so the next clearance alternates to EW.
        pulse(0);
        ticks(11);
        checks++; if (a_phase !== 2'd1) $display("[TB] FAIL alt_ns_clear: got %0d expected 1", a_phase); else passed++;
        ticks(2);
        checks++; if (a_phase !== 2'd2) $display("[TB] FAIL alt_ew_phase: got %0d expected 2", a_phase); else passed++;
        checks++; if (a_ew_en !== 1'b1) $display("[TB] FAIL alt_ew_en: got %b expected 1", a_ew_en); else passed++;
    endtask

    task automatic test_ew_return;
        pulse(1);
        ticks(11);
        checks++; if (a_phase !== 2'd3) $display("[TB] FAIL ret_ew_clear: got %0d expected 3", a_phase); else passed++;
        pulse(1);
        ticks(2);
        checks++; if (a_phase !== 2'd2) $display("[TB] FAIL ret_ew_phase: got %0d expected 2", a_phase); else passed++;
        checks++; if (a_timer !== 7'd10) $display("[TB] FAIL ret_ew_timer: got %0d expected 10", a_timer); else passed++;
        checks++; if (a_ns_en !== 1'b0) $display("[TB] FAIL ret_ew_ns_en: got %b expected 0", a_ns_en); else passed++;
    endtask

    task automatic test_mid_reset;
        ticks(5);
        checks++; if (a_timer !== 7'd5) $display("[TB] FAIL mid_pre_timer: got %0d expected 5", a_timer); else passed++;
        @(negedge clk);
        rst_n = 1'b0;
        sec_tick = 1'b1;
        ns_request = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
        ns_request = 1'b0;
        checks++; if (a_phase !== 2'd3) $display("[TB] FAIL mid_phase: got %0d expected 3", a_phase); else passed++;
        checks++; if (a_timer !== 7'd0) $display("[TB] FAIL mid_timer: got %0d expected 0", a_timer); else passed++;
        checks++; if (a_ns_en !== 1'b0) $display("[TB] FAIL mid_ns_en: got %b expected 0", a_ns_en); else passed++;
        checks++; if (a_ew_en !== 1'b0) $display("[TB] FAIL mid_ew_en: got %b expected 0", a_ew_en); else passed++;
        checks++; if (a_walk !== 1'b0) $display("[TB] FAIL mid_walk: got %b expected 0", a_walk); else passed++;
        rst_n = 1'b1;
        ticks(2);
        checks++; if (a_phase !== 2'd0) $display("[TB] FAIL mid_restart_phase: got %0d expected 0", a_phase); else passed++;
        checks++; if (a_timer !== 7'd10) $display("[TB] FAIL mid_restart_timer: got %0d expected 10", a_timer); else passed++;
    endtask

    initial begin
        test_reset();
        test_no_requests();
        test_ped_extend();
        test_saturation();
        test_ns_return();
        test_ew_return();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
